// File: rtl/phase_timer.sv
// phase_timer
// Counts a traffic-light phase down in whole seconds. A phase is loaded by a
// one-cycle `start` and decremented on each 1 Hz `enable` tick from the
// divider. When the last tick is consumed, `expired` pulses for one cycle.
// `timer_reset` pulses when a phase is loaded, so the divider restarts its
// count and the first tick arrives a full second after the phase begins.
// `hold` freezes the countdown while it is high.
//
// Priority, highest first: reset_n, start, hold, enable.
//
// Ports
//   clock        in   system clock; all logic updates on the rising edge
//   reset_n      in   synchronous reset, active-low
//   enable       in   1 Hz tick from the divider, one clock wide
//   start        in   one-cycle request to (re)load `duration` and run
//   duration     in   phase length in ticks; sampled only when start=1
//   hold         in   level; freezes the countdown while high
//   timer_reset  out  one-cycle pulse that restarts the divider
//   remaining    out  ticks left in the current phase
//   busy         out  high while a phase is running or held
//   expired      out  one-cycle pulse at the end of a phase
module phase_timer #(
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] duration,
  input  logic                   hold,
  output logic                   timer_reset,
  output logic [COUNT_WIDTH-1:0] remaining,
  output logic                   busy,
  output logic                   expired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] remaining_next;
  logic                   expired_next;
  logic                   timer_reset_next;
  logic                   busy_next;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    state_next       = state;
    remaining_next   = remaining;
    expired_next     = 1'b0;
    timer_reset_next = 1'b0;

    if (start) begin
      // A load wins over hold and over a coinciding final tick. A zero
      // duration ends at once: report expiry and go back to idle without
      // restarting the divider.
      if (duration != '0) begin
        remaining_next   = duration;
        timer_reset_next = 1'b1;
        state_next       = hold ? HOLD : RUN;
      end else begin
        remaining_next = '0;
        expired_next   = 1'b1;
        state_next     = IDLE;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (hold) begin
            // A tick arriving as hold rises is dropped.
            state_next = HOLD;
          end else if (enable) begin
            if (remaining > COUNT_WIDTH'(1)) begin
              remaining_next = remaining - COUNT_WIDTH'(1);
            end else begin
              // Final tick. Also covers a zero count, so the counter can
              // never wrap below zero.
              remaining_next = '0;
              expired_next   = 1'b1;
              state_next     = IDLE;
            end
          end
        end
        HOLD: begin
          // Frozen. A tick arriving as hold falls is dropped, and counting
          // resumes on the following cycle.
          if (!hold) state_next = RUN;
        end
        default: begin
          // IDLE ignores ticks.
          state_next = IDLE;
        end
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  // State and output registers. All outputs are registered.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before this clock edge.
    if (!reset_n) begin
      state       <= IDLE;
      remaining   <= '0;
      busy        <= 1'b0;
      expired     <= 1'b0;
      timer_reset <= 1'b0;
    end else begin
      state       <= state_next;
      remaining   <= remaining_next;
      busy        <= busy_next;
      expired     <= expired_next;
      timer_reset <= timer_reset_next;
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
// Directed testbench for phase_timer. Inputs change 1 time unit after each
// rising edge, and outputs are sampled at that same point, after the edge
// that produced them.
module tb_phase_timer;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       start;
  logic [5:0] duration;
  logic       hold;
  logic       timer_reset;
  logic [5:0] remaining;
  logic       busy;
  logic       expired;

  int checks = 0;
  int errors = 0;

  phase_timer #(.COUNT_WIDTH(6)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .start       (start),
    .duration    (duration),
    .hold        (hold),
    .timer_reset (timer_reset),
    .remaining   (remaining),
    .busy        (busy),
    .expired     (expired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Checks all four outputs against the expected values.
  task automatic expect_out(input string tag, input logic [5:0] rem,
                            input logic bsy, input logic exp, input logic tr);
    check({tag, ".remaining"},   32'(remaining),   32'(rem));
    check({tag, ".busy"},        32'(busy),        32'(bsy));
    check({tag, ".expired"},     32'(expired),     32'(exp));
    check({tag, ".timer_reset"}, 32'(timer_reset), 32'(tr));
  endtask

  // Advances one clock. Outputs from that edge are then stable for checking.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    enable = 1'b1;
    cyc();
    enable = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] d);
    start    = 1'b1;
    duration = d;
    cyc();
    start    = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    start    = 1'b0;
    duration = '0;
    hold     = 1'b0;

    // Reset state.
    cyc();
    cyc();
    expect_out("reset", 6'd0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cyc();
    expect_out("post_reset", 6'd0, 1'b0, 1'b0, 1'b0);

    // Basic phase: duration 3, ticks every 4 clocks.
    do_start(6'd3);
    expect_out("basic_start", 6'd3, 1'b1, 1'b0, 1'b1);
    for (int k = 3; k >= 1; k--) begin
      repeat (3) begin
        cyc();
        expect_out("basic_wait", 6'(k), 1'b1, 1'b0, 1'b0);
      end
      tick();
      expect_out("basic_tick", 6'(k - 1), (k > 1), (k == 1), 1'b0);
    end
    cyc();
    expect_out("basic_after", 6'd0, 1'b0, 1'b0, 1'b0);

    // Zero duration: immediate expiry, no divider restart.
    do_start(6'd0);
    expect_out("zero_start", 6'd0, 1'b0, 1'b1, 1'b0);
    cyc();
    expect_out("zero_after", 6'd0, 1'b0, 1'b0, 1'b0);

    // Hold: duration 5, two ticks, hold across three ticks, then resume.
    do_start(6'd5);
    expect_out("hold_start", 6'd5, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("hold_t1", 6'd4, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("hold_t2", 6'd3, 1'b1, 1'b0, 1'b0);
    hold = 1'b1;
    tick();                                   // tick as hold rises is dropped
    expect_out("hold_enter", 6'd3, 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      expect_out("hold_frozen", 6'd3, 1'b1, 1'b0, 1'b0);
    end
    hold = 1'b0;
    tick();                                   // tick as hold falls is dropped
    expect_out("hold_release", 6'd3, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("hold_r1", 6'd2, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("hold_r2", 6'd1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("hold_r3", 6'd0, 1'b0, 1'b1, 1'b0);
    cyc();
    expect_out("hold_after", 6'd0, 1'b0, 1'b0, 1'b0);

    // Restart collision: start with duration 4 on the final tick.
    do_start(6'd2);
    tick();
    expect_out("coll_t1", 6'd1, 1'b1, 1'b0, 1'b0);
    enable   = 1'b1;
    do_start(6'd4);
    enable   = 1'b0;
    expect_out("coll_load", 6'd4, 1'b1, 1'b0, 1'b1);
    for (int k = 4; k >= 1; k--) begin
      tick();
      expect_out("coll_tick", 6'(k - 1), (k > 1), (k == 1), 1'b0);
    end

    // Start together with hold loads and enters HOLD.
    hold = 1'b1;
    do_start(6'd2);
    expect_out("start_hold", 6'd2, 1'b1, 1'b0, 1'b1);
    tick();
    expect_out("start_hold_frozen", 6'd2, 1'b1, 1'b0, 1'b0);
    hold = 1'b0;

    // Restart with duration 0 from a running phase ends it at once.
    cyc();
    do_start(6'd0);
    expect_out("restart_zero", 6'd0, 1'b0, 1'b1, 1'b0);
    cyc();
    expect_out("restart_zero_after", 6'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-phase: no expiry, and later ticks leave the timer idle.
    do_start(6'd10);
    repeat (4) tick();
    expect_out("rst_mid_run", 6'd6, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    expect_out("rst_mid", 6'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    expect_out("rst_mid_after", 6'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      tick();
      expect_out("rst_mid_tick", 6'd0, 1'b0, 1'b0, 1'b0);
    end

    // Ticks in IDLE are ignored.
    repeat (5) begin
      tick();
      expect_out("idle_tick", 6'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
